ray_sphere_intersect: RTL and testbench
=======================================

Name: ray_sphere_intersect

Overview:
- Fully pipelined, fixed-point ray–sphere intersection unit for the ray-tracing datapath.
- Accepts one ray/sphere pair per cycle in signed Q8.8.
- Reports whether the ray hits the sphere in front of its origin, and the nearest hit distance t in Q8.8.
- Sits between the ray generator and the shading/compare stage; no backpressure.

Parameters:
- DATA_W, 16, width of every coordinate/radius/t operand (signed).
- FRAC_W, 8, fractional bits (Q8.8).

Ports:
- clock input 1 — rising-edge clock.
- reset input 1 — asynchronous, active-low reset (asserted when 0).
- valid_in input 1 — inputs valid this cycle; accepted unconditionally.
- ray_origin_x/_y/_z input DATA_W each — signed Q8.8 ray origin.
- ray_dir_x/_y/_z input DATA_W each — signed Q8.8 direction; must be unit length (a = 1 is not computed).
- sphere_center_x/_y/_z input DATA_W each — signed Q8.8 centre.
- sphere_radius input DATA_W — signed Q8.8 radius, non-negative.
- valid_out output 1 — result registers hold a valid result.
- hit output 1 — intersection found with t >= 0.
- t_value output DATA_W — signed Q8.8 distance to hit; 0 on miss.

Behaviour:
- Reset (reset == 0, async):
  - All pipeline valid bits, valid_out, hit and t_value clear to 0.
- Math (full precision inside, no intermediate overflow):
  - oc = origin − center: 17-bit Q9.8 per axis.
  - b = dot(oc, dir): Q.16 product sum, arithmetic-shift right by FRAC_W to Q.8, at least 28 bits.
  - c = dot(oc, oc) − r²: Q.16, at least 40 bits.
  - disc = b² − c: Q.16, at least 64 bits signed.
  - disc < 0 → miss.
  - Otherwise sq = isqrt(disc): integer floor square root of the Q.16 value, giving Q.8. If disc exceeds 2^32−1, saturate the sqrt input to 2^32−1.
  - t_near = −b − sq; t_far = −b + sq (Q.8).
  - hit = (disc >= 0) && (t_near >= 0); t_value = t_near.
  - t_value saturates to 0x7FFF if it exceeds the positive range.
  - On miss, t_value = 0.
- Tangent case: disc == 0 → hit, with t_near = −b if −b >= 0.
- Latency: exactly 6 cycles. Stages: 1 oc; 2 products; 3 b and c sums; 4 disc; 5 sqrt; 6 t/hit/saturation into the output registers.
- Throughput: one new input per cycle. Every valid_in produces exactly one result, in order.
- Output hold:
  - hit and t_value update only when a valid result leaves stage 6; otherwise they hold.
  - valid_out goes high on the first such result and stays high until reset.
  - Consumers sample results on the cycle a result emerges (tracked by a 6-cycle valid pipe), or at any later time before the next result.
- Reset mid-operation: all in-flight results are discarded; no output appears after reset release without a new valid_in.
- valid_in low: pipeline data may toggle, but the output registers do not change.

Optional Feature:
- Macro INSIDE_HIT_EN.
- Defined: when t_near < 0 and t_far >= 0 (origin inside the sphere), report hit = 1 and t_value = t_far, saturated as above.
- Undefined: that case reports a miss (hit = 0, t_value = 0).

Decomposition:
- Package ray_pkg:
  - typedef q88_t (signed DATA_W).
  - FRAC_W constant.
  - PIPE_LAT = 6 constant.
  - T_MAX = 16'h7FFF saturation constant.
- One sub-module, fixed_isqrt: combinational 32-bit-in / 16-bit-out restoring integer square root, used in stage 5.

Test Plan:
- Origin (0,0,0), dir (0,0,1), center (0,0,10), r 2 → hit = 1, t = 8.0 (0x0800) ±1 LSB, exactly 6 cycles after valid_in.
- Origin (5,0,0), same ray/sphere → hit = 0, t_value = 0.
- Origin (0,0,0), dir (0,0,−1), center (0,0,10), r 2 → hit = 0 (t_near = −12).
- Origin (−10,0,0), dir (1,0,0), center origin, r 2.5 → hit, t = 7.5. Origin (0,0,−10), dir +Z, r 3 → t = 7.0.
- Origin (0,0,0), dir (0.707,0,0.707) (0x00B5), center (5,0,5), r 2 → hit, t in [4, 8].
- Back-to-back valid_in on 3 consecutive cycles; reset pulse mid-flight; origin inside sphere (center origin, r 3, origin 0) → verify:
  - in-order results;
  - flush on reset;
  - INSIDE_HIT_EN gives t = 3.0 when defined, and a miss when undefined.

Source files
------------

// File: rtl/ray_pkg.sv
// Shared types and constants for the Q8.8 ray-sphere intersection datapath.
package ray_pkg;

   localparam int FRAC_W   = 8;
   localparam int PIPE_LAT = 6;

   typedef logic signed [15:0] q88_t;

   localparam q88_t T_MAX = 16'h7FFF;

endpackage

// File: rtl/fixed_isqrt.sv
// Combinational restoring integer square root: 32-bit radicand, 16-bit floor root.
module fixed_isqrt (
   input  logic [31:0] radicand,
   output logic [15:0] root
);

   logic [19:0] rem;
   logic [19:0] trial;
   logic [15:0] acc;

   // One result bit per radicand bit pair, MSB pair first.
   always_comb begin
      rem   = '0;
      trial = '0;
      acc   = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         rem   = {rem[17:0], radicand[31 - 2*i -: 2]};
         trial = {2'b00, acc, 2'b01};
         if (rem >= trial) begin
            rem = rem - trial;
            acc = {acc[14:0], 1'b1};
         end else begin
            acc = {acc[14:0], 1'b0};
         end
      end
      root = acc;
   end

endmodule

// File: rtl/ray_sphere_intersect.sv
// Six-stage pipelined Q8.8 ray-sphere intersection, one ray per cycle, no backpressure.
// Optional macro INSIDE_HIT_EN: report the far hit when the origin lies inside the sphere.
module ray_sphere_intersect #(
   parameter int DATA_W = $bits(ray_pkg::q88_t),
   parameter int FRAC_W = ray_pkg::FRAC_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] ray_origin_x,
   input  logic [DATA_W-1:0] ray_origin_y,
   input  logic [DATA_W-1:0] ray_origin_z,
   input  logic [DATA_W-1:0] ray_dir_x,
   input  logic [DATA_W-1:0] ray_dir_y,
   input  logic [DATA_W-1:0] ray_dir_z,
   input  logic [DATA_W-1:0] sphere_center_x,
   input  logic [DATA_W-1:0] sphere_center_y,
   input  logic [DATA_W-1:0] sphere_center_z,
   input  logic [DATA_W-1:0] sphere_radius,
   output logic              valid_out,
   output logic              hit,
   output logic [DATA_W-1:0] t_value
);

   import ray_pkg::*;

   localparam int OC_W  = DATA_W + 1;
   localparam int PD_W  = OC_W + DATA_W;
   localparam int PO_W  = 2 * OC_W;
   localparam int R2_W  = 2 * DATA_W;
   localparam int SUM_W = PO_W + 2;
   localparam int B_W   = SUM_W - FRAC_W;
   localparam int C_W   = PO_W + 6;
   localparam int D_W   = 64;
   localparam int T_W   = B_W + 2;
   localparam logic signed [T_W-1:0] T_LIM = T_W'(T_MAX);

   logic [PIPE_LAT-2:0] vld;

   logic signed [OC_W-1:0]   s1_oc_x, s1_oc_y, s1_oc_z;
   logic signed [DATA_W-1:0] s1_dir_x, s1_dir_y, s1_dir_z, s1_r;
   logic signed [PD_W-1:0]   s2_pd_x, s2_pd_y, s2_pd_z;
   logic signed [PO_W-1:0]   s2_po_x, s2_po_y, s2_po_z;
   logic signed [R2_W-1:0]   s2_r2;
   logic signed [SUM_W-1:0]  bsum;
   logic signed [B_W-1:0]    s3_b, s4_b, s5_b;
   logic signed [C_W-1:0]    s3_c;
   logic signed [D_W-1:0]    s4_disc;
   logic [31:0]              sq_in;
   logic [15:0]              sq, s5_sq;
   logic                     s5_neg;
   logic signed [T_W-1:0]    t_near, t_far;
   logic                     nxt_hit;
   logic [DATA_W-1:0]        nxt_t;

   function automatic logic [DATA_W-1:0] sat_t(input logic signed [T_W-1:0] v);
      return (v > T_LIM) ? DATA_W'(T_MAX) : v[DATA_W-1:0];
   endfunction

   always_comb begin
      bsum = SUM_W'(s2_pd_x) + SUM_W'(s2_pd_y) + SUM_W'(s2_pd_z);
   end

   // Negative discriminant feeds zero (result discarded); oversized values clamp to 2^32-1.
   always_comb begin
      if (s4_disc[D_W-1])
         sq_in = '0;
      else if (|s4_disc[D_W-2:32])
         sq_in = '1;
      else
         sq_in = s4_disc[31:0];
   end

   fixed_isqrt u_isqrt (
      .radicand (sq_in),
      .root     (sq)
   );

   always_ff @(posedge clock) begin
      s1_oc_x  <= OC_W'($signed(ray_origin_x)) - OC_W'($signed(sphere_center_x));
      s1_oc_y  <= OC_W'($signed(ray_origin_y)) - OC_W'($signed(sphere_center_y));
      s1_oc_z  <= OC_W'($signed(ray_origin_z)) - OC_W'($signed(sphere_center_z));
      s1_dir_x <= ray_dir_x;
      s1_dir_y <= ray_dir_y;
      s1_dir_z <= ray_dir_z;
      s1_r     <= sphere_radius;

      s2_pd_x <= PD_W'(s1_oc_x) * PD_W'(s1_dir_x);
      s2_pd_y <= PD_W'(s1_oc_y) * PD_W'(s1_dir_y);
      s2_pd_z <= PD_W'(s1_oc_z) * PD_W'(s1_dir_z);
      s2_po_x <= PO_W'(s1_oc_x) * PO_W'(s1_oc_x);
      s2_po_y <= PO_W'(s1_oc_y) * PO_W'(s1_oc_y);
      s2_po_z <= PO_W'(s1_oc_z) * PO_W'(s1_oc_z);
      s2_r2   <= R2_W'(s1_r) * R2_W'(s1_r);

      s3_b <= B_W'(bsum >>> FRAC_W);
      s3_c <= C_W'(s2_po_x) + C_W'(s2_po_y) + C_W'(s2_po_z) - C_W'(s2_r2);

      s4_b    <= s3_b;
      s4_disc <= D_W'(s3_b) * D_W'(s3_b) - D_W'(s3_c);

      s5_b   <= s4_b;
      s5_sq  <= sq;
      s5_neg <= s4_disc[D_W-1];
   end

   always_comb begin
      t_near  = -T_W'(s5_b) - T_W'($signed({1'b0, s5_sq}));
      t_far   = -T_W'(s5_b) + T_W'($signed({1'b0, s5_sq}));
      nxt_hit = 1'b0;
      nxt_t   = '0;
      if (!s5_neg && !t_near[T_W-1]) begin
         nxt_hit = 1'b1;
         nxt_t   = sat_t(t_near);
      end
`ifdef INSIDE_HIT_EN
      else if (!s5_neg && !t_far[T_W-1]) begin
         nxt_hit = 1'b1;
         nxt_t   = sat_t(t_far);
      end
`else
      else begin
         nxt_hit = 1'b0;
         nxt_t   = '0;
      end
`endif
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vld       <= '0;
         valid_out <= 1'b0;
         hit       <= 1'b0;
         t_value   <= '0;
      end else begin
         vld <= {vld[PIPE_LAT-3:0], valid_in};
         if (vld[PIPE_LAT-2]) begin
            valid_out <= 1'b1;
            hit       <= nxt_hit;
            t_value   <= nxt_t;
         end
      end
   end

endmodule

// File: tb/tb_ray_sphere_intersect.sv
// Self-checking bench for ray_sphere_intersect: directed table, latency/reset sequences, random vs model.
module tb_ray_sphere_intersect;

   typedef logic signed [15:0] q_t;
   typedef struct {
      q_t ox, oy, oz, dx, dy, dz, cx, cy, cz, r;
      logic        hit;
      logic [15:0] t;
   } vec_t;
   typedef struct {
      logic        hit;
      logic [15:0] t;
   } exp_t;

   localparam longint SQ_CAP = 64'h0000_0000_FFFF_FFFF;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic valid_in = 1'b0;
   q_t   ray_origin_x = '0, ray_origin_y = '0, ray_origin_z = '0;
   q_t   ray_dir_x = '0, ray_dir_y = '0, ray_dir_z = '0;
   q_t   sphere_center_x = '0, sphere_center_y = '0, sphere_center_z = '0;
   q_t   sphere_radius = '0;
   logic        valid_out, hit;
   logic [15:0] t_value;

   int checks = 0;
   int failures = 0;
   exp_t exp_q[$];
   logic        last_hit = 1'b0;
   logic [15:0] last_t = '0;
   logic [4:0]  vtrack = '0;

   ray_sphere_intersect dut (
      .clock           (clock),
      .reset           (reset),
      .valid_in        (valid_in),
      .ray_origin_x    (ray_origin_x),
      .ray_origin_y    (ray_origin_y),
      .ray_origin_z    (ray_origin_z),
      .ray_dir_x       (ray_dir_x),
      .ray_dir_y       (ray_dir_y),
      .ray_dir_z       (ray_dir_z),
      .sphere_center_x (sphere_center_x),
      .sphere_center_y (sphere_center_y),
      .sphere_center_z (sphere_center_z),
      .sphere_radius   (sphere_radius),
      .valid_out       (valid_out),
      .hit             (hit),
      .t_value         (t_value)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: plain integer arithmetic with a real-valued sqrt, trimmed to the exact floor.
   function automatic vec_t model(input vec_t v);
      longint ocx, ocy, ocz, b, c, disc, d, sq, tn, tf;
      ocx  = longint'(v.ox) - longint'(v.cx);
      ocy  = longint'(v.oy) - longint'(v.cy);
      ocz  = longint'(v.oz) - longint'(v.cz);
      b    = (ocx * longint'(v.dx) + ocy * longint'(v.dy) + ocz * longint'(v.dz)) >>> 8;
      c    = ocx * ocx + ocy * ocy + ocz * ocz - longint'(v.r) * longint'(v.r);
      disc = b * b - c;
      v.hit = 1'b0;
      v.t   = '0;
      if (disc < 0) return v;
      d  = (disc > SQ_CAP) ? SQ_CAP : disc;
      sq = longint'($sqrt(real'(d)));
      while (sq * sq > d) sq--;
      while ((sq + 1) * (sq + 1) <= d) sq++;
      tn = -b - sq;
      tf = -b + sq;
      if (tn >= 0) begin
         v.hit = 1'b1;
         v.t   = (tn > 32767) ? 16'h7FFF : 16'(tn);
      end
`ifdef INSIDE_HIT_EN
      else if (tf >= 0) begin
         v.hit = 1'b1;
         v.t   = (tf > 32767) ? 16'h7FFF : 16'(tf);
      end
`endif
      return v;
   endfunction

   function automatic vec_t mk(input logic [15:0] ox, oy, oz, dx, dy, dz, cx, cy, cz, r,
                               input logic h, input logic [15:0] t);
      vec_t v;
      v.ox = ox; v.oy = oy; v.oz = oz;
      v.dx = dx; v.dy = dy; v.dz = dz;
      v.cx = cx; v.cy = cy; v.cz = cz;
      v.r = r; v.hit = h; v.t = t;
      return v;
   endfunction

   function automatic q_t rnd_coord(input bit wide);
      if (wide) return q_t'($urandom_range(0, 65535));
      return q_t'(int'($urandom_range(0, 8192)) - 4096);
   endfunction

   function automatic vec_t rnd_vec();
      vec_t v;
      q_t dirs[6];
      bit wide;
      int unsigned k;
      dirs[0] = 16'sh0100; dirs[1] = -16'sh0100; dirs[2] = 16'sh00B5;
      dirs[3] = -16'sh00B5; dirs[4] = 16'sh0000; dirs[5] = 16'sh0080;
      wide = ($urandom_range(0, 3) == 0);
      v.ox = rnd_coord(wide); v.oy = rnd_coord(wide); v.oz = rnd_coord(wide);
      v.cx = rnd_coord(wide); v.cy = rnd_coord(wide); v.cz = rnd_coord(wide);
      k = $urandom_range(0, 5); v.dx = dirs[k];
      k = $urandom_range(0, 5); v.dy = dirs[k];
      k = $urandom_range(0, 5); v.dz = dirs[k];
      v.r = wide ? q_t'($urandom_range(0, 32767)) : q_t'($urandom_range(0, 2048));
      v.hit = 1'b0;
      v.t = '0;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      ray_origin_x = v.ox; ray_origin_y = v.oy; ray_origin_z = v.oz;
      ray_dir_x = v.dx; ray_dir_y = v.dy; ray_dir_z = v.dz;
      sphere_center_x = v.cx; sphere_center_y = v.cy; sphere_center_z = v.cz;
      sphere_radius = v.r;
   endtask

   // Called 1 time unit after a rising edge; returns at the same phase one cycle later.
   task automatic send(input vec_t v);
      exp_t e;
      drive(v);
      valid_in = 1'b1;
      e.hit = v.hit;
      e.t   = v.t;
      exp_q.push_back(e);
      last_hit = v.hit;
      last_t   = v.t;
      @(posedge clock);
      #1;
   endtask

   task automatic drain();
      for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
         @(posedge clock);
         #2;
      end
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clock);
      #1;
   endtask

   // Tracks in-flight valids independently and checks each result as it emerges.
   always @(posedge clock) begin
      logic emerge;
      exp_t e;
      emerge = vtrack[4] & reset;
      vtrack = reset ? {vtrack[3:0], valid_in} : 5'b0;
      if (emerge) begin
         #1;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_result actual=hit%0d_t%0h required=none", hit, t_value);
         end else begin
            e = exp_q.pop_front();
            check("result_valid_out", 32'(valid_out), 32'd1);
            check("result_hit", 32'(hit), 32'(e.hit));
            check("result_t", 32'(t_value), 32'(e.t));
         end
      end
   end

   initial begin
      vec_t tbl[9];
      vec_t v;
      logic inside_hit;
      logic [15:0] inside_t;
`ifdef INSIDE_HIT_EN
      inside_hit = 1'b1; inside_t = 16'h0300;
`else
      inside_hit = 1'b0; inside_t = 16'h0000;
`endif
      tbl[0] = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100,
                  16'h0000, 16'h0000, 16'h0A00, 16'h0200, 1'b1, 16'h0800);
      tbl[1] = mk(16'h0500, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100,
                  16'h0000, 16'h0000, 16'h0A00, 16'h0200, 1'b0, 16'h0000);
      tbl[2] = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFF00,
                  16'h0000, 16'h0000, 16'h0A00, 16'h0200, 1'b0, 16'h0000);
      tbl[3] = mk(16'hF600, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000,
                  16'h0000, 16'h0000, 16'h0000, 16'h0280, 1'b1, 16'h0780);
      tbl[4] = mk(16'h0000, 16'h0000, 16'hF600, 16'h0000, 16'h0000, 16'h0100,
                  16'h0000, 16'h0000, 16'h0000, 16'h0300, 1'b1, 16'h0700);
      tbl[5] = mk(16'h0000, 16'h0000, 16'h0000, 16'h00B5, 16'h0000, 16'h00B5,
                  16'h0500, 16'h0000, 16'h0500, 16'h0200, 1'b1, 16'h0513);
      tbl[6] = mk(16'h8100, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000,
                  16'h7F00, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h7FFF);
      tbl[7] = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100,
                  16'h0000, 16'h0000, 16'h0000, 16'h0300, inside_hit, inside_t);
      tbl[8] = mk(16'h0000, 16'h0200, 16'h0000, 16'h0000, 16'h0000, 16'h0100,
                  16'h0000, 16'h0000, 16'h0A00, 16'h0200, 1'b1, 16'h0A00);

      repeat (2) @(posedge clock);
      #1;
      check("reset_valid_out", 32'(valid_out), 32'd0);
      check("reset_hit", 32'(hit), 32'd0);
      check("reset_t", 32'(t_value), 32'd0);
      reset = 1'b1;
      @(posedge clock);
      #1;

      // Exact latency: valid_out must rise on the sixth edge after valid_in is taken.
      send(tbl[0]);
      valid_in = 1'b0;
      #1;
      check("latency_edge1", 32'(valid_out), 32'd0);
      for (int i = 2; i <= 6; i++) begin
         @(posedge clock);
         #2;
         check($sformatf("latency_edge%0d", i), 32'(valid_out), (i == 6) ? 32'd1 : 32'd0);
      end
      @(posedge clock);
      #1;

      // Whole table streamed back-to-back, results expected in order.
      for (int i = 0; i < 9; i++) send(tbl[i]);
      valid_in = 1'b0;
      drain();

      // Outputs hold while no valid result emerges, even with toggling inputs.
      for (int i = 0; i < 6; i++) begin
         v = rnd_vec();
         drive(v);
         valid_in = 1'b0;
         @(posedge clock);
         #1;
         check("hold_valid_out", 32'(valid_out), 32'd1);
         check("hold_hit", 32'(hit), 32'(last_hit));
         check("hold_t", 32'(t_value), 32'(last_t));
      end

      // Reset mid-flight: in-flight results discarded, nothing emerges afterwards.
      send(tbl[0]);
      send(tbl[3]);
      valid_in = 1'b0;
      @(posedge clock);
      #4;
      reset = 1'b0;
      exp_q.delete();
      #1;
      check("midrst_valid_out", 32'(valid_out), 32'd0);
      check("midrst_hit", 32'(hit), 32'd0);
      check("midrst_t", 32'(t_value), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock);
         #2;
         check("flush_valid_out", 32'(valid_out), 32'd0);
         check("flush_t", 32'(t_value), 32'd0);
      end
      @(posedge clock);
      #1;

      // Random traffic with gaps against the reference model.
      for (int i = 0; i < 400; i++) begin
         v = rnd_vec();
         if ($urandom_range(0, 9) < 7) begin
            send(model(v));
         end else begin
            drive(v);
            valid_in = 1'b0;
            @(posedge clock);
            #1;
         end
      end
      valid_in = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
